// File: rtl/aa_pkg.sv
// Shared types, kernel tables and accumulator helpers for the 3x3 AA sequencer.
// Kernel offsets are raster ordered; weights are 1/2/4 binomial, summing to 16.
package aa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    typedef logic [3:0] idx_t;

    localparam int   ACC_BITS = 12;
    localparam int   ROUND    = 8;
    localparam idx_t LAST_IDX = 4'd8;

    function automatic logic signed [1:0] kern_dx(input idx_t i);
        case (i)
            4'd0, 4'd3, 4'd6: kern_dx = 2'sb11;
            4'd1, 4'd4, 4'd7: kern_dx = 2'sb00;
            default:          kern_dx = 2'sb01;
        endcase
    endfunction

    function automatic logic signed [1:0] kern_dy(input idx_t i);
        case (i)
            4'd0, 4'd1, 4'd2: kern_dy = 2'sb11;
            4'd3, 4'd4, 4'd5: kern_dy = 2'sb00;
            default:          kern_dy = 2'sb01;
        endcase
    endfunction

    function automatic logic [2:0] kern_w(input idx_t i);
        case (i)
            4'd4:                   kern_w = 3'd4;
            4'd1, 4'd3, 4'd5, 4'd7: kern_w = 3'd2;
            default:                kern_w = 3'd1;
        endcase
    endfunction

    function automatic logic [ACC_BITS-1:0] mac(
        input logic [ACC_BITS-1:0] acc,
        input idx_t                i,
        input logic [7:0]          s
    );
        mac = acc + ACC_BITS'(kern_w(i)) * ACC_BITS'(s);
    endfunction

    function automatic logic [7:0] round16(input logic [ACC_BITS-1:0] acc);
        logic [ACC_BITS-1:0] t;
        t = acc + ACC_BITS'(ROUND);
        round16 = t[ACC_BITS-1:4];
    endfunction

endpackage

// File: rtl/aa_coord_gen.sv
// Neighbour coordinate generator for one kernel tap.
// AA_EDGE_CLAMP_EN: replicate edge pixels; otherwise coordinates wrap.
module aa_coord_gen
    import aa_pkg::*;
#(
    parameter int SCREEN_WIDTH       = 1024,
    parameter int SCREEN_HEIGHT      = 768,
    parameter int SCREEN_WIDTH_BITS  = 11,
    parameter int SCREEN_HEIGHT_BITS = 10
) (
    input  logic [SCREEN_WIDTH_BITS-1:0]  i_x,
    input  logic [SCREEN_HEIGHT_BITS-1:0] i_y,
    input  idx_t                          i_idx,
    output logic [SCREEN_WIDTH_BITS-1:0]  o_x,
    output logic [SCREEN_HEIGHT_BITS-1:0] o_y
);
    localparam int WB = SCREEN_WIDTH_BITS;
    localparam int HB = SCREEN_HEIGHT_BITS;

    logic signed [1:0] w_dx;
    logic signed [1:0] w_dy;
    logic [WB:0]       w_sx;
    logic [HB:0]       w_sy;

    assign w_dx = kern_dx(i_idx);
    assign w_dy = kern_dy(i_idx);

    // One extra bit so that -1 and +SIZE are visible before truncation
    assign w_sx = {1'b0, i_x} + {{(WB-1){w_dx[1]}}, w_dx};
    assign w_sy = {1'b0, i_y} + {{(HB-1){w_dy[1]}}, w_dy};

`ifdef AA_EDGE_CLAMP_EN
    always_comb begin
        o_x = w_sx[WB-1:0];
        if (w_dx[1] && i_x == '0)
            o_x = '0;
        else if (w_sx >= (WB+1)'(SCREEN_WIDTH))
            o_x = WB'(SCREEN_WIDTH - 1);
    end

    always_comb begin
        o_y = w_sy[HB-1:0];
        if (w_dy[1] && i_y == '0)
            o_y = '0;
        else if (w_sy >= (HB+1)'(SCREEN_HEIGHT))
            o_y = HB'(SCREEN_HEIGHT - 1);
    end
`else
    assign o_x = w_sx[WB-1:0];
    assign o_y = w_sy[HB-1:0];
`endif

endmodule

// File: rtl/aa_sample_sequencer.sv
// Sequences one shared pixel evaluator over a 3x3 neighbourhood and filters it.
// Edge handling is selected by the AA_EDGE_CLAMP_EN macro (see aa_coord_gen).
module aa_sample_sequencer
    import aa_pkg::*;
#(
    parameter int SCREEN_WIDTH       = 1024,
    parameter int SCREEN_HEIGHT      = 768,
    parameter int SCREEN_WIDTH_BITS  = 11,
    parameter int SCREEN_HEIGHT_BITS = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [SCREEN_WIDTH_BITS-1:0]  x,
    input  logic [SCREEN_HEIGHT_BITS-1:0] y,
    output logic                          sample_en,
    output logic [SCREEN_WIDTH_BITS-1:0]  sample_x,
    output logic [SCREEN_HEIGHT_BITS-1:0] sample_y,
    input  logic [7:0]                    sample_r,
    input  logic [7:0]                    sample_g,
    input  logic [7:0]                    sample_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    r_new,
    output logic [7:0]                    g_new,
    output logic [7:0]                    b_new
);
    state_t                          r_state;
    idx_t                            r_idx;
    logic [SCREEN_WIDTH_BITS-1:0]    r_x;
    logic [SCREEN_HEIGHT_BITS-1:0]   r_y;
    logic [ACC_BITS-1:0]             r_acc_r;
    logic [ACC_BITS-1:0]             r_acc_g;
    logic [ACC_BITS-1:0]             r_acc_b;

    logic [SCREEN_WIDTH_BITS-1:0]    w_base_x;
    logic [SCREEN_HEIGHT_BITS-1:0]   w_base_y;
    idx_t                            w_gen_idx;
    logic [SCREEN_WIDTH_BITS-1:0]    w_gen_x;
    logic [SCREEN_HEIGHT_BITS-1:0]   w_gen_y;
    logic [ACC_BITS-1:0]             w_sum_r;
    logic [ACC_BITS-1:0]             w_sum_g;
    logic [ACC_BITS-1:0]             w_sum_b;

    // Sample coordinates are registered one tap ahead of the accumulation
    assign w_base_x  = (r_state == ST_IDLE) ? x : r_x;
    assign w_base_y  = (r_state == ST_IDLE) ? y : r_y;
    assign w_gen_idx = (r_state == ST_IDLE) ? '0 : r_idx + 4'd1;

    assign w_sum_r = mac(r_acc_r, r_idx, sample_r);
    assign w_sum_g = mac(r_acc_g, r_idx, sample_g);
    assign w_sum_b = mac(r_acc_b, r_idx, sample_b);

    aa_coord_gen #(
        .SCREEN_WIDTH      (SCREEN_WIDTH),
        .SCREEN_HEIGHT     (SCREEN_HEIGHT),
        .SCREEN_WIDTH_BITS (SCREEN_WIDTH_BITS),
        .SCREEN_HEIGHT_BITS(SCREEN_HEIGHT_BITS)
    ) u_coord_gen (
        .i_x  (w_base_x),
        .i_y  (w_base_y),
        .i_idx(w_gen_idx),
        .o_x  (w_gen_x),
        .o_y  (w_gen_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_acc_r   <= '0;
            r_acc_g   <= '0;
            r_acc_b   <= '0;
            pix_ready <= 1'b0;
            sample_en <= 1'b0;
            sample_x  <= '0;
            sample_y  <= '0;
            out_valid <= 1'b0;
            r_new     <= '0;
            g_new     <= '0;
            b_new     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    pix_ready <= 1'b1;
                    if (pix_ready && pix_valid) begin
                        r_x       <= x;
                        r_y       <= y;
                        r_idx     <= '0;
                        r_acc_r   <= '0;
                        r_acc_g   <= '0;
                        r_acc_b   <= '0;
                        sample_x  <= w_gen_x;
                        sample_y  <= w_gen_y;
                        sample_en <= 1'b1;
                        pix_ready <= 1'b0;
                        r_state   <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_acc_r <= w_sum_r;
                    r_acc_g <= w_sum_g;
                    r_acc_b <= w_sum_b;
                    if (r_idx == LAST_IDX) begin
                        sample_en <= 1'b0;
                        out_valid <= 1'b1;
                        r_new     <= round16(w_sum_r);
                        g_new     <= round16(w_sum_g);
                        b_new     <= round16(w_sum_b);
                        r_state   <= ST_DONE;
                    end else begin
                        r_idx    <= r_idx + 4'd1;
                        sample_x <= w_gen_x;
                        sample_y <= w_gen_y;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pix_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aa_sample_sequencer.sv
// Self-checking bench for aa_sample_sequencer with a behavioural 3x3 filter model.
// Honours AA_EDGE_CLAMP_EN in the same way as the design build.
module tb_aa_sample_sequencer;
    localparam int SW = 1024;
    localparam int SH = 768;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic        sample_en;
    logic [10:0] sample_x;
    logic [9:0]  sample_y;
    logic [7:0]  sample_r, sample_g, sample_b;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  r_new, g_new, b_new;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;
    int cx      = 0;
    int cy      = 0;
    logic [20:0] q[$];

    aa_sample_sequencer dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .x(x), .y(y),
        .sample_en(sample_en), .sample_x(sample_x), .sample_y(sample_y),
        .sample_r(sample_r), .sample_g(sample_g), .sample_b(sample_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .r_new(r_new), .g_new(g_new), .b_new(b_new)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] colour(int m, int px, int py);
        int r, g, b;
        case (m)
            0: begin r = 100; g = 150; b = 200; end
            1: begin
                r = (px == cx && py == cy) ? 255 : 0;
                g = r; b = r;
            end
            default: begin
                r = (px * 7 + py * 13 + 5) & 255;
                g = ((px * 3) ^ (py * 11)) & 255;
                b = (px + py * py) & 255;
            end
        endcase
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    always_comb {sample_r, sample_g, sample_b} = colour(mode, int'(sample_x), int'(sample_y));

    always @(negedge clk) if (sample_en) q.push_back({sample_x, sample_y});

    function automatic int fold(int v, int size, int span);
`ifdef AA_EDGE_CLAMP_EN
        if (v < 0) return 0;
        if (v >= size) return size - 1;
        return v;
`else
        return (v + span) % span;
`endif
    endfunction

    function automatic logic [20:0] nb(int px, int py, int i);
        int nx, ny;
        nx = fold(px + (i % 3) - 1, SW, 2048);
        ny = fold(py + (i / 3) - 1, SH, 1024);
        return {11'(nx), 10'(ny)};
    endfunction

    function automatic logic [23:0] model(int px, int py);
        int sr, sg, sb, w;
        logic [23:0] c;
        sr = 0; sg = 0; sb = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                w = (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1);
                c = colour(mode, fold(px + dx, SW, 2048), fold(py + dy, SH, 1024));
                sr += w * c[23:16];
                sg += w * c[15:8];
                sb += w * c[7:0];
            end
        return {8'((sr + 8) / 16), 8'((sg + 8) / 16), 8'((sb + 8) / 16)};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic accept(int px, int py);
        int k;
        @(negedge clk);
        x = 11'(px); y = 10'(py); pix_valid = 1'b1;
        q.delete();
        k = 0;
        while (!pix_ready && k < 50) begin @(negedge clk); k++; end
        if (!pix_ready) timeout("pix_ready");
        @(posedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        if (!out_valid) timeout("out_valid");
    endtask

    task automatic run_req(int px, int py, output logic [23:0] res, output int lat);
        accept(px, py);
        wait_valid(lat);
        res = {r_new, g_new, b_new};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        int          px;
        int          py;
        int          m;
        logic [23:0] exp;
    } vec_t;

    vec_t        vt[5];
    logic [23:0] res, exp;
    int          lat, px, py, cnt;
    int          pulse[$];

    initial begin
        vt[0] = '{500, 400, 0, 24'h6496C8};
        vt[1] = '{10, 10, 1, 24'h404040};
        vt[2] = '{0, 0, 0, 24'h6496C8};
`ifdef AA_EDGE_CLAMP_EN
        vt[3] = '{0, 0, 1, 24'h8F8F8F};
        vt[4] = '{1023, 767, 1, 24'h8F8F8F};
`else
        vt[3] = '{0, 0, 1, 24'h404040};
        vt[4] = '{1023, 767, 1, 24'h404040};
`endif

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_state",
                  {pix_ready, sample_en, out_valid, sample_x, sample_y, r_new, g_new, b_new},
                  64'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            mode = vt[i].m; cx = vt[i].px; cy = vt[i].py;
            run_req(vt[i].px, vt[i].py, res, lat);
            check("vec_rgb", res, vt[i].exp);
            check("vec_model", res, model(vt[i].px, vt[i].py));
            check("vec_latency", lat, 10);
            check("vec_nsamples", q.size(), 9);
            if (q.size() == 9) begin
                for (int k = 0; k < 9; k++)
                    check("vec_coord", q[k], nb(vt[i].px, vt[i].py, k));
                if (vt[i].px == 0 && vt[i].py == 0) begin
`ifdef AA_EDGE_CLAMP_EN
                    check("clamp_idx0", q[0], {11'd0, 10'd0});
                    check("clamp_idx2", q[2], {11'd1, 10'd0});
                    check("clamp_idx8", q[8], {11'd1, 10'd1});
`else
                    check("wrap_idx0", q[0], {11'd2047, 10'd1023});
`endif
                end
            end
        end

        mode = 2;
        for (int i = 0; i < 20; i++) begin
            px = $urandom_range(SW - 1);
            py = $urandom_range(SH - 1);
            if (i % 5 == 0) px = 0;
            if (i % 5 == 1) py = SH - 1;
            if (i % 5 == 2) px = SW - 1;
            if (i % 5 == 3) py = 0;
            run_req(px, py, res, lat);
            check("rand_rgb", res, model(px, py));
        end

        // Backpressure with a pending request
        px = $urandom_range(SW - 1); py = $urandom_range(SH - 1);
        exp = model(px, py);
        accept(px, py);
        wait_valid(lat);
        x = 11'(px + 1); y = 10'(py); pix_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", {out_valid, pix_ready, r_new, g_new, b_new}, {2'b10, exp});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_ready", pix_ready, 1'b1);
        @(negedge clk);
        pix_valid = 1'b0;
        check("bp_accepted", {pix_ready, sample_en}, 2'b01);
        wait_valid(lat);
        check("bp_latency", lat, 10);
        check("bp_rgb", {r_new, g_new, b_new}, model(px + 1, py));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of SAMPLE at idx 4
        mode = 2;
        accept(300, 200);
        for (int i = 1; i < 5; i++) @(negedge clk);
        check("mid_sample_en", sample_en, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_idle", {sample_en, out_valid, pix_ready}, 3'b000);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("mid_rst_no_valid", cnt, 0);
        mode = 0;
        run_req(321, 123, res, lat);
        check("mid_rst_flat", res, 24'h6496C8);
        check("mid_rst_latency", lat, 10);

        // Back-to-back
        mode = 2;
        px = $urandom_range(SW - 1); py = $urandom_range(SH - 1);
        exp = model(px, py);
        @(negedge clk);
        x = 11'(px); y = 10'(py); pix_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 100 && pulse.size() < 5; c++) begin
            @(negedge clk);
            if (out_valid) begin
                pulse.push_back(c);
                check("b2b_rgb", {r_new, g_new, b_new}, exp);
            end
        end
        pix_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_pulses", pulse.size(), 5);
        for (int i = 1; i < pulse.size(); i++)
            check("b2b_spacing", pulse[i] - pulse[i-1], 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
